fft_stream_bridge: RTL and testbench



---
 rtl/fft_stream_bridge_pkg.sv | 30 +++
 rtl/fft_stream_bridge_if.sv | 13 +
 rtl/fft_frame_buffer.sv | 24 ++
 rtl/fft_stream_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_fft_stream_bridge.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stream_bridge_pkg.sv
// Shared types and register map for the FFT stream bridge.
package fft_bridge_pkg;

    // Frame path states: CPU fills, bridge streams, waits for and captures results.
    typedef enum logic [2:0] {
        FILL,
        STREAM,
        WAIT_OUT,
        CAPTURE,
        DONE
    } bridge_state_e;

    // Byte offsets inside the bridge window.
    localparam logic [31:0] CTRL_OFF    = 32'h000;
    localparam logic [31:0] STATUS_OFF  = 32'h004;
    localparam logic [31:0] DATA_IN_OFF = 32'h008;
    localparam logic [31:0] RESULT_BASE = 32'h400;

    // CTRL bit positions.
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    // STATUS bit positions.
    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_DONE      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_ERR       = 3;
    localparam int unsigned ST_COUNT_LSB = 16;

endpackage

// File: rtl/fft_stream_bridge_if.sv
// CPU data-bus port of the FFT stream bridge.
interface fft_stream_bridge_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              bus_en_i;
    logic [3:0]        bus_we_i;
    logic [ADDR_W-1:0] bus_addr_i;
    logic [31:0]       bus_wdata_i;
    logic [31:0]       bus_rdata_o;

    modport master (output bus_en_i, bus_we_i, bus_addr_i, bus_wdata_i, input bus_rdata_o);
    modport slave  (input bus_en_i, bus_we_i, bus_addr_i, bus_wdata_i, output bus_rdata_o);
endinterface

// File: rtl/fft_frame_buffer.sv
// Complex sample buffer: one write port, one asynchronous read port, no reset.
module fft_frame_buffer #(
    parameter  int unsigned W     = 16,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [2*W-1:0] wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output logic [2*W-1:0] rdata_o
);
    logic [2*W-1:0] mem_q [DEPTH];

    // Store one {imag, real} word per write strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft_stream_bridge.sv
// Memory-mapped bridge between the CPU data bus and a streaming FFT core.
// Optional FFT_BRIDGE_IRQ_EN adds irq_o and CTRL bit2 IRQ_MASK.
module fft_stream_bridge
    import fft_bridge_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned N_POINTS  = 64,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_stream_bridge_if.slave   bus,
    output logic                 fft_rst_o,
    output logic                 fft_in_valid_o,
    output logic [IN_WIDTH-1:0]  fft_din_r_o,
    output logic [IN_WIDTH-1:0]  fft_din_i_o,
    input  logic                 fft_out_valid_i,
    input  logic [OUT_WIDTH-1:0] fft_dout_r_i,
    input  logic [OUT_WIDTH-1:0] fft_dout_i_i
`ifdef FFT_BRIDGE_IRQ_EN
    ,
    output logic                 irq_o
`endif
);
    localparam int unsigned AW = $clog2(N_POINTS);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(N_POINTS);
    localparam logic [CW-1:0] LAST = CW'(N_POINTS - 1);

    bridge_state_e         state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cap_q, cap_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic                  in_valid_q, in_valid_d;
    logic [IN_WIDTH-1:0]   din_r_q, din_i_q;
    logic                  clr_q;
    logic [31:0]           rdata_q, rdata_d, status_w;

    logic [ADDR_W-1:0]     addr;
    logic [31:0]           addr32, res_off;
    logic                  wr_acc, rd_acc;
    logic                  ctrl_hit, status_hit, din_hit, res_hit;
    logic                  start_wr, clear_wr, data_wr, busy;
    logic                  in_we, cap_we;
    logic [AW-1:0]         in_waddr;
    logic [2*IN_WIDTH-1:0] in_rd;
    logic [2*OUT_WIDTH-1:0] res_rd;

    // Bus decode on word addresses; result window bounded by the frame length.
    assign addr       = bus.bus_addr_i;
    assign addr32     = 32'(addr);
    assign res_off    = addr32 - RESULT_BASE;
    assign wr_acc     = bus.bus_en_i & (|bus.bus_we_i);
    assign rd_acc     = bus.bus_en_i & ~(|bus.bus_we_i);
    assign ctrl_hit   = addr32[31:2] == CTRL_OFF[31:2];
    assign status_hit = addr32[31:2] == STATUS_OFF[31:2];
    assign din_hit    = addr32[31:2] == DATA_IN_OFF[31:2];
    assign res_hit    = (addr32 >= RESULT_BASE) && (res_off < 32'(4 * N_POINTS));
    assign clear_wr   = wr_acc & ctrl_hit & bus.bus_wdata_i[CTRL_CLEAR];
    assign start_wr   = wr_acc & ctrl_hit & bus.bus_wdata_i[CTRL_START] & ~bus.bus_wdata_i[CTRL_CLEAR];
    assign data_wr    = wr_acc & din_hit;
    assign busy       = (state_q == STREAM) || (state_q == WAIT_OUT) || (state_q == CAPTURE);

    fft_frame_buffer #(.W(IN_WIDTH), .DEPTH(N_POINTS)) u_in_buf (
        .clk     (clk),
        .we_i    (in_we),
        .waddr_i (in_waddr),
        .wdata_i ({bus.bus_wdata_i[16 +: IN_WIDTH], bus.bus_wdata_i[0 +: IN_WIDTH]}),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (in_rd)
    );

    fft_frame_buffer #(.W(OUT_WIDTH), .DEPTH(N_POINTS)) u_res_buf (
        .clk     (clk),
        .we_i    (cap_we),
        .waddr_i (cap_q[AW-1:0]),
        .wdata_i ({fft_dout_i_i, fft_dout_r_i}),
        .raddr_i (res_off[AW+1:2]),
        .rdata_o (res_rd)
    );

    // Next-state logic for the frame path; CLEAR overrides every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        cap_d      = cap_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        in_we      = 1'b0;
        in_waddr   = count_q[AW-1:0];
        cap_we     = 1'b0;
        in_valid_d = 1'b0;
        if (clear_wr) begin
            state_d = FILL;
            count_d = '0;
            idx_d   = '0;
            cap_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                FILL, DONE: begin
                    if (data_wr) begin
                        if (state_q == DONE) begin
                            in_we    = 1'b1;
                            in_waddr = '0;
                            count_d  = CW'(1);
                            state_d  = FILL;
                        end else if (count_q < FULL) begin
                            in_we   = 1'b1;
                            count_d = count_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (start_wr) begin
                        if (count_q == FULL) begin
                            state_d = STREAM;
                            idx_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    in_valid_d = 1'b1;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = WAIT_OUT;
                        cap_d   = '0;
                    end
                end
                // WAIT_OUT enters with cap_q = 0, so both states share the store path.
                WAIT_OUT, CAPTURE: begin
                    if (fft_out_valid_i) begin
                        cap_we  = 1'b1;
                        cap_d   = cap_q + 1'b1;
                        state_d = (cap_q == LAST) ? DONE : CAPTURE;
                    end
                end
                default: state_d = FILL;
            endcase
            if (busy && data_wr) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Read mux: STATUS and sign-extended results, everything else reads zero.
    always_comb begin
        rdata_d  = '0;
        status_w = '0;
        status_w[ST_BUSY] = busy;
        status_w[ST_DONE] = (state_q == DONE);
        status_w[ST_OVF]  = ovf_q;
        status_w[ST_ERR]  = err_q;
        status_w[ST_COUNT_LSB +: 16] = 16'(count_q);
        if (rd_acc) begin
            if (status_hit) begin
                rdata_d = status_w;
            end else if (res_hit) begin
                rdata_d = {16'($signed(res_rd[OUT_WIDTH +: OUT_WIDTH])),
                           16'($signed(res_rd[0 +: OUT_WIDTH]))};
            end
        end
    end

    // State, counters, flags, FFT drive and bus read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            count_q    <= '0;
            idx_q      <= '0;
            cap_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            in_valid_q <= 1'b0;
            din_r_q    <= '0;
            din_i_q    <= '0;
            clr_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            cap_q      <= cap_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            in_valid_q <= in_valid_d;
            clr_q      <= clear_wr;
            rdata_q    <= rdata_d;
            if (in_valid_d) begin
                din_r_q <= in_rd[0 +: IN_WIDTH];
                din_i_q <= in_rd[IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    assign bus.bus_rdata_o = rdata_q;
    assign fft_rst_o       = rst | clr_q;
    assign fft_in_valid_o  = in_valid_q;
    assign fft_din_r_o     = din_r_q;
    assign fft_din_i_o     = din_i_q;

`ifdef FFT_BRIDGE_IRQ_EN
    logic mask_q;

    // Interrupt mask follows CTRL bit2 on every CTRL write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 1'b0;
        end else if (wr_acc && ctrl_hit) begin
            mask_q <= bus.bus_wdata_i[2];
        end
    end

    assign irq_o = (state_q == DONE) & mask_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.bus_wdata_i, addr32, res_off};
endmodule

// File: tb/tb_fft_stream_bridge.sv
// Scoreboard bench for fft_stream_bridge with a frame-level reference model.
module tb_fft_stream_bridge;
    localparam int unsigned IW  = 12;
    localparam int unsigned OW  = 12;
    localparam int unsigned N   = 8;
    localparam int unsigned AWD = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stream_bridge_if #(.ADDR_W(AWD)) bus_if ();
    logic          fft_rst, in_valid, out_valid;
    logic [IW-1:0] din_r, din_i;
    logic [OW-1:0] dout_r, dout_i;
`ifdef FFT_BRIDGE_IRQ_EN
    logic          irq;
`endif

    fft_stream_bridge #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .N_POINTS(N), .ADDR_W(AWD)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus_if),
        .fft_rst_o       (fft_rst),
        .fft_in_valid_o  (in_valid),
        .fft_din_r_o     (din_r),
        .fft_din_i_o     (din_i),
        .fft_out_valid_i (out_valid),
        .fft_dout_r_i    (dout_r),
        .fft_dout_i_i    (dout_i)
`ifdef FFT_BRIDGE_IRQ_EN
        ,
        .irq_o           (irq)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the bridge at register/frame level.
    int              m_count;
    bit              m_busy, m_done, m_ovf, m_err;
    logic [2*IW-1:0] m_in  [N];
    logic [31:0]     m_res [N];
    logic [31:0]     pend_res [N];

    logic [2*IW-1:0] din_exp_q [$];
    logic [31:0]     rd_exp_q  [$];
    string           rd_name_q [$];

    int fft_mode    = 0;
    int frames_done = 0;
    logic rd_seen;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sx(logic [OW-1:0] v);
        int s;
        s = int'(v);
        if (s >= (1 << (OW - 1))) s = s - (1 << OW);
        return 16'(s);
    endfunction

    function automatic logic [31:0] status_exp();
        return (32'(m_count) << 16) | (32'(m_err) << 3) | (32'(m_ovf) << 2) |
               (32'(m_done) << 1) | 32'(m_busy);
    endfunction

    // One bus cycle; called just after a negedge, returns on the next one.
    task automatic access(bit en, logic [3:0] we, logic [31:0] addr, logic [31:0] data);
        bus_if.bus_en_i    = en;
        bus_if.bus_we_i    = we;
        bus_if.bus_addr_i  = addr[AWD-1:0];
        bus_if.bus_wdata_i = data;
        @(negedge clk);
        bus_if.bus_en_i = 1'b0;
        bus_if.bus_we_i = 4'h0;
    endtask

    task automatic idle(int n);
        repeat (n) access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(logic [31:0] addr, logic [31:0] exp, string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        access(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr_data(logic [31:0] d);
        logic [2*IW-1:0] s;
        s = {d[16 +: IW], d[0 +: IW]};
        if (m_busy) m_ovf = 1;
        else if (m_done) begin
            m_in[0] = s; m_count = 1; m_done = 0;
        end else if (m_count < N) begin
            m_in[m_count] = s; m_count++;
        end else m_ovf = 1;
        access(1'b1, 4'($urandom_range(1, 15)), 32'h008, d);
    endtask

    task automatic start();
        if (!m_busy) begin
            if (m_count == N) begin
                m_busy = 1; m_done = 0;
                for (int k = 0; k < N; k++) din_exp_q.push_back(m_in[k]);
            end else m_err = 1;
        end
        access(1'b1, 4'hF, 32'h000, 32'h5);
    endtask

    task automatic clear(logic [31:0] val);
        m_count = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_err = 0;
        access(1'b1, 4'hF, 32'h000, val);
        check("clr_fft_rst_hi", fft_rst, 1);
        check("clr_in_valid_lo", in_valid, 0);
`ifdef FFT_BRIDGE_IRQ_EN
        check("clr_irq_lo", irq, 0);
`endif
        idle(1);
        check("clr_fft_rst_lo", fft_rst, 0);
    endtask

    task automatic wait_frame(int target);
        int n = 0;
        while (frames_done < target && n < 400) begin
            idle(1);
            n++;
        end
        total++;
        if (frames_done < target) begin
            bad++;
            $display("FAIL frame_timeout: got %0d frames want %0d", frames_done, target);
        end
        idle(6);
        m_busy = 0; m_done = 1;
        for (int k = 0; k < N; k++) m_res[k] = pend_res[k];
    endtask

    task automatic read_results();
        for (int k = 0; k < N; k++)
            rd(32'h400 + 32'(4 * k), m_res[k], $sformatf("result%0d", k));
    endtask

    // FFT core model: after a full N-beat burst, emit N results with gaps.
    task automatic emit_frame();
        logic [OW-1:0] r, i;
        int gap;
        for (int k = 0; k < N; k++) begin
            gap = (fft_mode == 0) ? int'($urandom_range(0, 2)) : (fft_mode == 2) ? 2 : 0;
            repeat (gap) @(negedge clk);
`ifdef FFT_BRIDGE_IRQ_EN
            if (k == N - 1) check("irq_before_last", irq, 0);
`endif
            r = (fft_mode == 1) ? OW'(-3) : OW'($urandom);
            i = OW'($urandom);
            out_valid = 1'b1; dout_r = r; dout_i = i;
            pend_res[k] = {sx(i), sx(r)};
            @(negedge clk);
            out_valid = 1'b0;
        end
`ifdef FFT_BRIDGE_IRQ_EN
        check("irq_after_last", irq, 1);
`endif
        frames_done++;
        repeat (2) @(negedge clk);
        out_valid = 1'b1; dout_r = OW'($urandom); dout_i = OW'($urandom);
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    initial begin
        int beats = 0;
        out_valid = 1'b0; dout_r = '0; dout_i = '0;
        forever begin
            @(negedge clk);
            if (rst) beats = 0;
            else if (in_valid) beats++;
            else if (beats != 0) begin
                if (beats == N) emit_frame();
                beats = 0;
            end
        end
    end

    // Stream monitor: every in_valid beat must match the next queued sample.
    initial forever begin
        @(negedge clk);
        if (!rst && in_valid) begin
            if (din_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL din_unexpected: got %h want no beat", {din_i, din_r});
            end else check("din", 32'({din_i, din_r}), 32'(din_exp_q.pop_front()));
        end
    end

    // Read monitor: rdata is compared one cycle after each read access.
    always @(posedge clk) rd_seen <= bus_if.bus_en_i && (bus_if.bus_we_i == 4'h0);

    initial forever begin
        @(negedge clk);
        if (rd_seen === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %h want no read", bus_if.bus_rdata_o);
            end else check(rd_name_q.pop_front(), bus_if.bus_rdata_o, rd_exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.bus_en_i = 1'b0; bus_if.bus_we_i = 4'h0;
        bus_if.bus_addr_i = '0; bus_if.bus_wdata_i = '0;
        rst = 1'b1;
        m_count = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_err = 0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus_if.bus_rdata_o, 0);
        check("rst_in_valid", in_valid, 0);
        check("rst_din", 32'({din_i, din_r}), 0);
        check("rst_fft_rst", fft_rst, 1);
        rst = 1'b0;
        rd(32'h004, status_exp(), "status_after_rst");

        // Frame with constant -3 real outputs.
        fft_mode = 1;
        for (int k = 0; k < N; k++) wr_data($urandom);
        rd(32'h004, status_exp(), "status_full");
        start();
        rd(32'h004, status_exp(), "status_busy");
        wait_frame(1);
        rd(32'h004, status_exp(), "status_done");
        read_results();
        rd(32'h00C, 32'h0, "unmapped_0c");
        rd(32'h000, 32'h0, "ctrl_read");
        rd(32'h400 + 32'(4 * N), 32'h0, "result_beyond");

        // Short frame START, then overfill.
        for (int k = 0; k < 5; k++) wr_data($urandom);
        start();
        rd(32'h004, status_exp(), "status_err");
        for (int k = 0; k < 3; k++) wr_data($urandom);
        wr_data($urandom);
        rd(32'h004, status_exp(), "status_ovf");

        // Frame with 2-cycle output gaps.
        fft_mode = 2;
        start();
        wait_frame(2);
        rd(32'h004, status_exp(), "status_gap_done");
        read_results();

        // Random frames with writes and START while busy.
        for (int f = 0; f < 3; f++) begin
            clear(32'h2);
            fft_mode = 0;
            for (int k = 0; k < N; k++) wr_data($urandom);
            start();
            wr_data($urandom);
            start();
            rd(32'h004, status_exp(), "status_busy_ovf");
            wait_frame(3 + f);
            rd(32'h004, status_exp(), "status_rand_done");
            read_results();
        end

        // CLEAR (with START also set) in the third streaming cycle.
        clear(32'h2);
        for (int k = 0; k < N; k++) wr_data($urandom);
        start();
        idle(2);
        clear(32'h3);
        check("beats_before_clear", 32'(N - din_exp_q.size()), 2);
        din_exp_q.delete();
        idle(4);
        rd(32'h004, status_exp(), "status_after_clear");
        rd(32'h400, m_res[0], "result_kept");
        rd(32'h404 + 32'(4 * (N - 2)), m_res[N-1], "result_last_kept");

        idle(4);
        check("din_queue_empty", din_exp_q.size(), 0);
        check("rd_queue_empty", rd_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
